// File: rtl/fault_inject_data_mem.sv
// fault_inject_data_mem: word memory with stuck-at and one-shot flip fault injection (optional PARITY_EN)
module fault_inject_data_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_sel,
  input  logic [DATA_W-1:0] cfg_wdata,
  output logic              fault_fired,
  output logic              parity_err
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic {IDLE, RESP} state_t;
  state_t state, state_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] sa0_mask, sa1_mask, flip_mask, raw, faulted;
  logic [ADDR_W-1:0] flip_addr;
  logic [15:0] flip_cnt;
  logic accept, rd_hit, fire;
  assign accept = req_valid & req_ready;
  assign raw = mem[req_addr];
  assign rd_hit = accept & ~req_we & (req_addr == flip_addr) & (flip_cnt != 16'd0);
  assign fire = rd_hit & (flip_cnt == 16'd1);
  assign faulted = ((raw & ~sa0_mask) | sa1_mask) ^ (fire ? flip_mask : '0);
  // handshake state: one request in flight, response held until consumed
  always_comb begin
    state_next = state;
    req_ready = state == IDLE;
    rsp_valid = state == RESP;
    if (state == IDLE && req_valid) state_next = RESP;
    if (state == RESP && rsp_ready) state_next = IDLE;
  end
  // state register; reset drops any pending response at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_next;
  end
  // data storage is fault-free and never reset
  always_ff @(posedge clk) begin
    if (accept && req_we) mem[req_addr] <= req_wdata;
  end
  // response registers capture faulted read data at acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata <= '0;
      fault_fired <= 1'b0;
    end else if (accept) begin
      rsp_rdata <= req_we ? '0 : faulted;
      fault_fired <= fire;
    end
  end
  // fault configuration; a count load beats a same-edge decrement
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa0_mask <= '0;
      sa1_mask <= '0;
      flip_mask <= '0;
      flip_addr <= '0;
      flip_cnt <= '0;
    end else begin
      if (cfg_we && cfg_sel == 3'd0) sa0_mask <= cfg_wdata;
      if (cfg_we && cfg_sel == 3'd1) sa1_mask <= cfg_wdata;
      if (cfg_we && cfg_sel == 3'd2) flip_mask <= cfg_wdata;
      if (cfg_we && cfg_sel == 3'd3) flip_addr <= cfg_wdata[ADDR_W-1:0];
      if (cfg_we && cfg_sel == 3'd4) flip_cnt <= cfg_wdata[15:0];
      else if (rd_hit) flip_cnt <= flip_cnt - 16'd1;
    end
  end
`ifdef PARITY_EN
  logic par_mem [DEPTH];
  // parity bit stored alongside each word from the written data
  always_ff @(posedge clk) begin
    if (accept && req_we) par_mem[req_addr] <= ^req_wdata;
  end
  // flag any odd-weight difference between stored and delivered data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_err <= 1'b0;
    else if (accept) parity_err <= ~req_we & ((^faulted) ^ par_mem[req_addr]);
  end
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_fault_inject_data_mem.sv
// tb_fault_inject_data_mem: directed checks of handshake, stuck-at, counted flip and parity
module tb_fault_inject_data_mem;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1, cfg_we = 1'b0;
  logic [9:0] req_addr = '0;
  logic [31:0] req_wdata = '0, cfg_wdata = '0;
  logic [2:0] cfg_sel = '0;
  logic req_ready, rsp_valid, fault_fired, parity_err;
  logic [31:0] rsp_rdata;
  logic [31:0] rd;
  logic ff, pe, vl;
  int errors = 0, checks = 0;

  fault_inject_data_mem dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata),
    .fault_fired(fault_fired), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cfg(input logic [2:0] sel, input logic [31:0] data);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_sel = sel;
    cfg_wdata = data;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic access(input logic we, input logic [9:0] addr, input logic [31:0] wd,
                        output logic [31:0] r, output logic f, output logic p, output logic v);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) check("ready_timeout", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we = we;
    req_addr = addr;
    req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    v = rsp_valid;
    r = rsp_rdata;
    f = fault_fired;
    p = parity_err;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_fired", {31'd0, fault_fired}, 32'd0);
    rst = 1'b0;
    // T1
    access(1'b1, 10'd5, 32'hDEADBEEF, rd, ff, pe, vl);
    check("t1_wr_valid", {31'd0, vl}, 32'd1);
    check("t1_wr_rdata", rd, 32'd0);
    access(1'b0, 10'd5, 32'h0, rd, ff, pe, vl);
    check("t1_rd_valid", {31'd0, vl}, 32'd1);
    check("t1_rd_data", rd, 32'hDEADBEEF);
    check("t1_rd_fired", {31'd0, ff}, 32'd0);
    check("t1_rd_perr", {31'd0, pe}, 32'd0);
    // T2
    cfg(3'd0, 32'h1);
    access(1'b0, 10'd5, 32'h0, rd, ff, pe, vl);
    check("t2_sa0", rd, 32'hDEADBEEE);
    cfg(3'd0, 32'h0);
    access(1'b0, 10'd5, 32'h0, rd, ff, pe, vl);
    check("t2_sa0_clear", rd, 32'hDEADBEEF);
    // T3
    cfg(3'd0, 32'h80000000);
    cfg(3'd1, 32'h80000000);
    access(1'b1, 10'd7, 32'h0, rd, ff, pe, vl);
    access(1'b0, 10'd7, 32'h0, rd, ff, pe, vl);
    check("t3_sa1_wins", rd, 32'h80000000);
    cfg(3'd0, 32'h0);
    cfg(3'd1, 32'h0);
    access(1'b0, 10'd7, 32'h0, rd, ff, pe, vl);
    check("t3_true_data", rd, 32'h0);
    // T4
    access(1'b1, 10'd6, 32'h12345678, rd, ff, pe, vl);
    cfg(3'd3, 32'd5);
    cfg(3'd2, 32'hFF);
    cfg(3'd4, 32'd3);
    access(1'b0, 10'd5, 32'h0, rd, ff, pe, vl);
    check("t4_r1", rd, 32'hDEADBEEF);
    check("t4_r1_fired", {31'd0, ff}, 32'd0);
    access(1'b1, 10'd5, 32'hDEADBEEF, rd, ff, pe, vl);
    access(1'b0, 10'd6, 32'h0, rd, ff, pe, vl);
    check("t4_a6", rd, 32'h12345678);
    access(1'b0, 10'd5, 32'h0, rd, ff, pe, vl);
    check("t4_r2", rd, 32'hDEADBEEF);
    check("t4_r2_fired", {31'd0, ff}, 32'd0);
    access(1'b0, 10'd6, 32'h0, rd, ff, pe, vl);
    check("t4_a6_fired", {31'd0, ff}, 32'd0);
    access(1'b0, 10'd5, 32'h0, rd, ff, pe, vl);
    check("t4_r3", rd, 32'hDEADBE10);
    check("t4_r3_fired", {31'd0, ff}, 32'd1);
    access(1'b0, 10'd5, 32'h0, rd, ff, pe, vl);
    check("t4_r4", rd, 32'hDEADBEEF);
    check("t4_r4_fired", {31'd0, ff}, 32'd0);
    // T5 backpressure
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = 10'd5;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t5_valid", {31'd0, rsp_valid}, 32'd1);
      check("t5_data", rsp_rdata, 32'hDEADBEEF);
      check("t5_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t5_idle_valid", {31'd0, rsp_valid}, 32'd0);
    check("t5_idle_ready", {31'd0, req_ready}, 32'd1);
    // T5 reset while a response is pending
    cfg(3'd1, 32'hFFFF0000);
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("t5_pending", rsp_rdata, 32'hFFFFBEEF);
    rst = 1'b1;
    #1;
    check("t5_rst_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    access(1'b0, 10'd5, 32'h0, rd, ff, pe, vl);
    check("t5_masks_cleared", rd, 32'hDEADBEEF);
    // T6
    access(1'b1, 10'd2, 32'h3, rd, ff, pe, vl);
    cfg(3'd1, 32'h4);
    access(1'b0, 10'd2, 32'h0, rd, ff, pe, vl);
    check("t6_odd_data", rd, 32'h7);
`ifdef PARITY_EN
    check("t6_odd_perr", {31'd0, pe}, 32'd1);
`else
    check("t6_odd_perr", {31'd0, pe}, 32'd0);
`endif
    cfg(3'd1, 32'hC);
    access(1'b0, 10'd2, 32'h0, rd, ff, pe, vl);
    check("t6_even_data", rd, 32'hF);
    check("t6_even_perr", {31'd0, pe}, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
